// File: rtl/core_pkg.sv
// Shared opcode constants, controller state encoding and source-register usage decode.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package core_pkg;

   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JAL    = 7'd111;
   localparam logic [6:0] OP_JALR   = 7'd103;
   localparam logic [6:0] OP_OP     = 7'd51;
   localparam logic [6:0] OP_OPIMM  = 7'd19;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } ctrl_state_t;

   // Pipeline register controls, packed so the priority mux assigns them as one bundle.
   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_clr;
      logic id_ex_clr;
   } ctrl_t;

   // rs1 is read by R-type, I-type ALU, loads, stores, branches and JALR.
   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_OP) || (op == OP_OPIMM) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
   endfunction

   // rs2 is read only by R-type, stores and branches.
   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detect: load in ID/EX whose rd feeds a used source of the IF/ID instruction.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result only feeds the stall decision in pipeline_ctrl.
module hazard_detect
   import core_pkg::*;
(
   input  logic [6:0] opcode_id_ex,
   input  logic [4:0] rd_id_ex,
   input  logic [6:0] opcode_if_id,
   input  logic [4:0] rs1_if_id,
   input  logic [4:0] rs2_if_id,
   output logic       load_use
);

   logic ld_in_ex;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is never a real dependency, so a load targeting x0 cannot cause a stall.
   assign ld_in_ex = (opcode_id_ex == OP_LOAD) && (rd_id_ex != 5'd0);
   assign rs1_hit  = uses_rs1(opcode_if_id) && (rs1_if_id == rd_id_ex);
   assign rs2_hit  = uses_rs2(opcode_if_id) && (rs2_if_id == rd_id_ex);
   assign load_use = ld_in_ex && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register control: post-reset bubble fill, memory freeze, EX redirect flush, load-use stall.
// Latency: enables/clears are combinational (same cycle); counters visible one cycle after the event.
// Backpressure: dmem_ready low with a memory access freezes every pipeline register until it rises.
module pipeline_ctrl
   import core_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int INIT_BUBBLES = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_ex,
   input  logic [6:0]       opcode_id_ex,
   input  logic [4:0]       rd_id_ex,
   input  logic [6:0]       opcode_if_id,
   input  logic [4:0]       rs1_if_id,
   input  logic [4:0]       rs2_if_id,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_clr,
   output logic             id_ex_clr,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   ctrl_state_t state;
   ctrl_state_t state_nxt;
   logic [2:0]  bub_cnt;
   logic        init_done;
   logic        load_use;
   logic        mem_hold;
   logic        flush_evt;
   logic        stall_evt;
   ctrl_t       ctrl;

   hazard_detect u_hazard_detect (
      .opcode_id_ex (opcode_id_ex),
      .rd_id_ex     (rd_id_ex),
      .opcode_if_id (opcode_if_id),
      .rs1_if_id    (rs1_if_id),
      .rs2_if_id    (rs2_if_id),
      .load_use     (load_use)
   );

   assign init_done = (bub_cnt == 3'(INIT_BUBBLES - 1));

   // The pipeline stays frozen either on a fresh stalled access in RUN or while still waiting in MEM_WAIT.
   // MEM_WAIT ignores mem_req: the access that caused the wait is still in EX/MEM.
   assign mem_hold = ((state == ST_RUN) && mem_req && !dmem_ready) ||
                     ((state == ST_MEM_WAIT) && !dmem_ready);

   // State register and bubble counter; reset always lands in INIT with no leftover stall state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_INIT;
         bub_cnt <= 3'd0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) begin
            bub_cnt <= init_done ? 3'd0 : bub_cnt + 3'd1;
         end
      end
   end

   // Next-state: INIT counts out the bubbles, RUN enters MEM_WAIT on a stalled access, release goes back to RUN.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:     if (init_done) state_nxt = ST_RUN;
         ST_RUN:      if (mem_hold) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (!mem_hold) state_nxt = ST_RUN;
         default:     state_nxt = ST_INIT;
      endcase
   end

   // Output mux by priority: init bubbles, memory freeze, flush, load-use, normal flow.
   always_comb begin
      ctrl      = '{pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
                    mem_wb_en: 1'b1, if_id_clr: 1'b0, id_ex_clr: 1'b0};
      flush_evt = 1'b0;
      stall_evt = 1'b0;
      if ((state != ST_RUN) && (state != ST_MEM_WAIT)) begin
         ctrl.if_id_clr = 1'b1;
         ctrl.id_ex_clr = 1'b1;
      end else if (mem_hold) begin
         ctrl      = '0;
         stall_evt = 1'b1;
      end else if (flush_ex) begin
         ctrl.if_id_clr = 1'b1;
         ctrl.id_ex_clr = 1'b1;
         flush_evt      = 1'b1;
      end else if (load_use) begin
         ctrl.pc_en     = 1'b0;
         ctrl.if_id_en  = 1'b0;
         ctrl.id_ex_clr = 1'b1;
         stall_evt      = 1'b1;
      end
   end

   assign pc_en     = ctrl.pc_en;
   assign if_id_en  = ctrl.if_id_en;
   assign id_ex_en  = ctrl.id_ex_en;
   assign ex_mem_en = ctrl.ex_mem_en;
   assign mem_wb_en = ctrl.mem_wb_en;
   assign if_id_clr = ctrl.if_id_clr;
   assign id_ex_clr = ctrl.id_ex_clr;

   // Saturating event counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
         if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and pipeline-register control for the 5-stage RISC-V core. It takes the EX-stage redirect request from the branch/jump flush logic and applies it to the pipeline registers. It also detects load-use hazards and freezes the whole pipeline while data memory is not ready. It sequences a short bubble-fill after reset and keeps saturating performance counters for flushes and stalls.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- INIT_BUBBLES, 2, cycles of forced bubbles after reset release (1..7)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush_ex  in  1  branch taken / JAL / JALR resolved in EX (same-cycle, combinational source)
- opcode_id_ex  in  7  opcode of instruction in ID/EX
- rd_id_ex  in  5  destination register in ID/EX
- opcode_if_id  in  7  opcode of instruction in IF/ID
- rs1_if_id, rs2_if_id  in  5 each  source registers in IF/ID
- mem_req  in  1  EX/MEM holds a load (opcode 3) or store (opcode 35)
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_clr, id_ex_clr  out  1 each  synchronous bubble insert (clear to NOP) at next edge
- flush_cnt, stall_cnt  out  CNT_W each  saturating event counters

## Operation
- FSM states: INIT, RUN, MEM_WAIT. The state register is reset asynchronously to INIT. A 3-bit bubble counter is reset to 0.
- INIT: all enables 1, if_id_clr=id_ex_clr=1. The bubble counter increments each cycle and the FSM moves to RUN when it reaches INIT_BUBBLES-1. No hazard inputs are evaluated.
- RUN, decided by priority:
  1. Memory stall: mem_req=1 and dmem_ready=0. All enables 0, both clr 0, next state MEM_WAIT, stall_cnt+1.
  2. Flush: flush_ex=1. All enables 1, if_id_clr=1, id_ex_clr=1, flush_cnt+1.
  3. Load-use: opcode_id_ex=3, rd_id_ex≠0, and a match on a used source. rs1 is used for opcodes 51, 19, 3, 35, 99, 103. rs2 is used for opcodes 51, 35, 99. Response: pc_en=0, if_id_en=0, id_ex_clr=1, remaining enables 1, stall_cnt+1.
  4. Otherwise all enables 1, clr 0.
- MEM_WAIT:
  - dmem_ready=0: hold all enables 0, stall_cnt+1.
  - dmem_ready=1: behave exactly as RUN rules 2–4 for this cycle (the memory stall is released) and return to RUN.
- Flush and load-use are mutually exclusive by construction, since a branch/jump in EX is not a load. The priority is fixed regardless.
- Counters saturate at 2^CNT_W−1 and do not wrap.

## Timing
- All outputs except the counters are Mealy: combinational from the state and the current inputs, valid in the same cycle. The flush_ex→clr path is a single-cycle combinational path.
- Counters and state update on the rising clk edge. Counter values are visible the cycle after the event.
- Reset values while rst_n=0:
  - state INIT
  - enables 1, if_id_clr=1, id_ex_clr=1
  - flush_cnt=0, stall_cnt=0
- Reset asserted mid-MEM_WAIT goes immediately to INIT. No pending state survives.
- Flush latency: the redirect takes effect at the next edge. Exactly two wrong-path instructions (those in IF/ID and ID/EX) are squashed.
- Load-use costs exactly 1 bubble. A memory stall costs N cycles where N is the number of cycles with dmem_ready=0.
- flush_ex held high across a memory stall is counted once, on the release cycle.

## Structure
- The shared package core_pkg holds:
  - opcode constants: OP_LOAD=3, OP_STORE=35, OP_BRANCH=99, OP_JAL=111, OP_JALR=103, OP_OP=51, OP_OPIMM=19
  - state enum ctrl_state_t
- One sub-module, hazard_detect. It is purely combinational and implements the load-use compare with its rs1/rs2 usage decode.
- The FSM, the priority mux and the counters live in pipeline_ctrl.

## Test plan
- Reset then release → if_id_clr=id_ex_clr=1 for exactly 2 cycles, then 0. Counters read 0.
- BEQ in EX with flush_ex=1 for one cycle → both clr=1 and all enables=1 that cycle. flush_cnt goes 0→1 on the next cycle.
- lw x5 in ID/EX, add x6,x5,x1 in IF/ID → pc_en=if_id_en=0 and id_ex_clr=1 for 1 cycle, stall_cnt=1. Same with rd=x0 → no stall.
- mem_req=1 with dmem_ready low for 3 cycles → all enables 0 for 3 cycles. Release on cycle 4 returns to RUN; stall_cnt=3.
- flush_ex=1 throughout a 2-cycle memory stall → clr asserted only on the release cycle, flush_cnt=1, stall_cnt=2.
- Preload counters near the limit with CNT_W=4 and drive 20 flushes → flush_cnt holds at 15. Assert rst_n low mid-MEM_WAIT → immediate INIT and counters 0.
